// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides: single-cycle ops 000-110,
// iterative shift-add multiply for 111, result and flags held until consumed.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_n,
  output logic                 flag_v
);

  localparam int unsigned SW  = $clog2(WIDTH);
  localparam int unsigned CW  = SW + 1;
  localparam int unsigned RW  = 2 * WIDTH;
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  ra, rb;
  logic [2:0]        rop;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     acc, mcand;
  logic [WIDTH-1:0]  mplier;

  logic [WIDTH-1:0]  alu_c;
  logic              alu_cf_c, alu_vf_c;
  logic [SW-1:0]     sh_c;
  logic [WIDTH:0]    wide_c;
  logic              mul_last_c;

  // Multiply runs WIDTH shift-add steps, then one cycle to register the product
  assign mul_last_c = (cnt == CW'(WIDTH));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_next = (op == 3'b111) ? MUL : EXEC;
      EXEC:    state_next = DONE;
      MUL:     if (mul_last_c) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ALU on the captured operands; shift carry is the last bit out
  always_comb begin
    alu_c    = '0;
    alu_cf_c = 1'b0;
    alu_vf_c = 1'b0;
    wide_c   = '0;
    sh_c     = rb[SW-1:0];
    case (rop)
      3'b000: begin
        wide_c   = {1'b0, ra} + {1'b0, rb};
        alu_c    = wide_c[WIDTH-1:0];
        alu_cf_c = wide_c[WIDTH];
        alu_vf_c = (ra[MSB] == rb[MSB]) && (alu_c[MSB] != ra[MSB]);
      end
      3'b001: begin
        alu_c    = ra - rb;
        alu_cf_c = (ra < rb);
        alu_vf_c = (ra[MSB] != rb[MSB]) && (alu_c[MSB] != ra[MSB]);
      end
      3'b010: alu_c = ra & rb;
      3'b011: alu_c = ra | rb;
      3'b100: alu_c = ra ^ rb;
      3'b101: begin
        wide_c   = {1'b0, ra} << sh_c;
        alu_c    = wide_c[WIDTH-1:0];
        alu_cf_c = wide_c[WIDTH];
      end
      3'b110: begin
        wide_c   = {ra, 1'b0} >> sh_c;
        alu_c    = wide_c[WIDTH:1];
        alu_cf_c = wide_c[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rop       <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: if (in_valid && in_ready) begin
          ra     <= a;
          rb     <= b;
          rop    <= op;
          cnt    <= '0;
          acc    <= '0;
          mcand  <= {WIDTH'(0), a};
          mplier <= b;
        end
        EXEC: begin
          result <= {WIDTH'(0), alu_c};
          flag_z <= (alu_c == '0);
          flag_c <= alu_cf_c;
          flag_n <= alu_c[MSB];
          flag_v <= alu_vf_c;
        end
        MUL: begin
          if (mul_last_c) begin
            result <= acc;
            flag_z <= (acc == '0);
            flag_c <= (acc[RW-1:WIDTH] != '0);
            flag_n <= acc[RW-1];
            flag_v <= 1'b0;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=8) against an arithmetic
// reference model; latency is counted with the accept cycle as cycle 1.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_z, flag_c, flag_n, flag_v;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {z, c, n, v, result[15:0]}
  function automatic logic [19:0] model(input int unsigned ai, input int unsigned bi,
                                        input int unsigned opi);
    int unsigned r, sh;
    int          sa, sb, ss;
    bit          c, v, z, n;
    sh = bi % 8;
    sa = (ai >= 128) ? int'(ai) - 256 : int'(ai);
    sb = (bi >= 128) ? int'(bi) - 256 : int'(bi);
    c = 0; v = 0; r = 0;
    case (opi)
      0: begin r = (ai + bi) % 256; c = (ai + bi) > 255; ss = sa + sb; v = (ss > 127) || (ss < -128); end
      1: begin r = (ai + 256 - bi) % 256; c = ai < bi; ss = sa - sb; v = (ss > 127) || (ss < -128); end
      2: r = ai & bi;
      3: r = ai | bi;
      4: r = ai ^ bi;
      5: begin r = (ai << sh) % 256; c = (sh != 0) && (((ai >> (8 - sh)) & 1) == 1); end
      6: begin r = ai >> sh; c = (sh != 0) && (((ai >> (sh - 1)) & 1) == 1); end
      default: begin r = ai * bi; c = r > 255; end
    endcase
    n = (opi == 7) ? (r >= 32768) : (((r >> 7) & 1) == 1);
    z = (r == 0);
    return {z, c, n, v, 16'(r)};
  endfunction

  task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] opi,
                       output int lat);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1; a = ai; b = bi; op = opi;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic verify(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] opi,
                        input int lat);
    logic [19:0] exp;
    exp = model(ai, bi, opi);
    check("latency", 32'(lat), (opi == 3'b111) ? 10 : 2);
    check("out_valid", 32'(out_valid), 1);
    check("result", 32'(result), 32'(exp[15:0]));
    check("flags_zcnv", 32'({flag_z, flag_c, flag_n, flag_v}), 32'(exp[19:16]));
  endtask

  task automatic consume(input int hold);
    logic [15:0] held;
    held = result;
    out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_result", 32'(result), 32'(held));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 0);
    check("drain_in_ready", 32'(in_ready), 1);
  endtask

  task automatic run(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] opi);
    int lat;
    issue(ai, bi, opi, lat);
    verify(ai, bi, opi, lat);
    consume($urandom_range(0, 2));
  endtask

  initial begin
    int          lat;
    logic [15:0] held;
    bit          seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", 32'({flag_z, flag_c, flag_n, flag_v}), 0);
    rst = 1'b0;

    // Reset in the fourth multiply cycle must abort the product entirely
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'b111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 0);

    run(8'hFF, 8'h01, 3'b000);
    run(8'h7F, 8'h01, 3'b000);
    run(8'h03, 8'h05, 3'b001);
    run(8'h80, 8'h01, 3'b001);
    run(8'h81, 8'h09, 3'b101);
    run(8'h01, 8'h00, 3'b110);
    run(8'h80, 8'h07, 3'b110);
    run(8'hFF, 8'hFF, 3'b111);
    run(8'h00, 8'h37, 3'b111);
    run(8'hF0, 8'h3C, 3'b010);
    run(8'hF0, 8'h0F, 3'b011);
    run(8'hAA, 8'hAA, 3'b100);

    // Backpressure: new request presented while the result is held
    issue(8'h12, 8'h34, 3'b000, lat);
    verify(8'h12, 8'h34, 3'b000, lat);
    held = result;
    in_valid = 1'b1; a = 8'h55; b = 8'h0A; op = 3'b001;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_result", 32'(result), 32'(held));
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", 32'(in_ready), 1);
    check("bp_release_ov", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    verify(8'h55, 8'h0A, 3'b001, lat);
    consume(0);

    for (int i = 0; i < 60; i++)
      run(8'($urandom), 8'($urandom), 3'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
